cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001: Parameter NUM_UNITS, default 4, number of functional units sharing the common data bus (2..8).
- REQ-002: Parameter DATA_W, default 32, result width.
- REQ-003: Parameter TAG_W, default 6, reservation-station tag width.
- REQ-004: clock  input  1  single clock; all state updates on the rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: CDB_rts  input  NUM_UNITS  per-unit request-to-send; bit i held high while unit i has a finished result.
- REQ-007: unit_data  input  NUM_UNITS*DATA_W  per-unit result, packed with unit i at bits [i*DATA_W +: DATA_W].
- REQ-008: unit_source  input  NUM_UNITS*TAG_W  per-unit producing reservation-station tag, packed the same way.
- REQ-009: unit_write  input  NUM_UNITS  per-unit "driving result" strobe; unit i asserts it only while CDB_xmit[i] is high.
- REQ-010: CDB_xmit  output  NUM_UNITS  registered one-hot grant to units.
- REQ-011: CDB_data  output  DATA_W  registered broadcast result.
- REQ-012: CDB_source  output  TAG_W  registered broadcast tag.
- REQ-013: CDB_write  output  1  registered broadcast-valid strobe.
- REQ-014: error  output  1  sticky protocol-violation flag.

Function
- REQ-015: CDB_xmit SHALL have at most one bit set in every cycle.
- REQ-016: On each rising edge the arbiter SHALL form the candidate set CDB_rts & ~CDB_xmit, which excludes the unit granted in the current cycle.
- REQ-017: Grant selection SHALL be round-robin: the first candidate searching upward from (last_grant+1) mod NUM_UNITS.
- REQ-018: last_grant SHALL update to the selected index whenever a grant is issued.
- REQ-019: CDB_xmit[i] SHALL be high for exactly one cycle per grant.
- REQ-020: Back-to-back grants to different units SHALL be allowed.
- REQ-021: The same unit SHALL never be granted in two consecutive cycles.
- REQ-022: Request latency: CDB_rts[i] sampled high at edge k with unit i selected -> CDB_xmit[i] high from edge k to edge k+1.
- REQ-023: At the edge that ends the grant cycle, the arbiter SHALL register the granted unit's unit_data and unit_source into CDB_data and CDB_source, and set CDB_write to unit_write[i].
- REQ-024: Broadcast latency SHALL be 2 cycles from the edge sampling CDB_rts; CDB_write SHALL be high for exactly 1 cycle.
- REQ-025: In cycles without a grant, CDB_write SHALL be 0 and CDB_data/CDB_source SHALL hold their previous values.
- REQ-026: If no candidate exists, CDB_xmit SHALL go to 0 and last_grant SHALL be unchanged.
- REQ-027: A unit that drops CDB_rts before it is granted SHALL simply not be granted; no error is raised.
- REQ-028: Width rule: unit index i SHALL be computed in clog2(NUM_UNITS) bits, with wrap-around from NUM_UNITS-1 to 0.

Reset
- REQ-029: While reset is high, CDB_xmit, CDB_data, CDB_source, CDB_write and error SHALL be 0, and last_grant SHALL be NUM_UNITS-1, so unit 0 has first priority.
- REQ-030: Reset asserted mid-grant SHALL abort the grant with no broadcast.
- REQ-031: The first grant after reset release SHALL be issued at the first edge with reset low.

Configuration
- REQ-032: With CDB_ERROR_CHECK_EN defined, error SHALL be set at an edge on either violation: (a) unit_write[j] high while CDB_xmit[j] is low; (b) CDB_xmit[i] high while unit_write[i] is low.
- REQ-033: error SHALL remain set until reset.
- REQ-034: With CDB_ERROR_CHECK_EN defined, a violation SHALL NOT alter arbitration or the broadcast.
- REQ-035: Without CDB_ERROR_CHECK_EN, error SHALL be tied to 0 and no checking logic SHALL be present.

Verification
- REQ-036: Single request: CDB_rts=4'b0100 from edge 1, unit 2 drives data=10, tag=5, write during its grant -> CDB_xmit=4'b0100 in cycle 1-2; CDB_data=10, CDB_source=5, CDB_write=1 in cycle 2-3; error=0.
- REQ-037: Simultaneous requests: CDB_rts=4'b1111 held, each unit dropping rts after its grant -> grants in order 0,1,2,3 on consecutive cycles; four consecutive CDB_write pulses carrying each unit's tag.
- REQ-038: Fairness: units 0 and 3 hold rts continuously -> grants alternate 0,3,0,3; neither unit is granted twice in a row.
- REQ-039: Reset mid-grant: reset pulsed while CDB_xmit=4'b0010 -> all outputs 0 immediately; after release, unit 1 is re-granted first if its rts is still high.
- REQ-040: Error check (macro defined): unit 1 asserts unit_write with no grant -> error=1 at the next edge and stays 1; grant order is unchanged. Macro undefined -> error=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus arbiter with registered grant and broadcast.
// Define CDB_ERROR_CHECK_EN to enable the sticky unit_write/CDB_xmit protocol checker.
module cdb_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        CDB_rts,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    input  logic [NUM_UNITS*TAG_W-1:0]  unit_source,
    input  logic [NUM_UNITS-1:0]        unit_write,
    output logic [NUM_UNITS-1:0]        CDB_xmit,
    output logic [DATA_W-1:0]           CDB_data,
    output logic [TAG_W-1:0]            CDB_source,
    output logic                        CDB_write,
    output logic                        error
);
    localparam int IW = $clog2(NUM_UNITS);

    logic [IW-1:0]        last_grant, sel, idx;
    logic [NUM_UNITS-1:0] cand;
    logic                 found;

    // Downward scan so the nearest candidate above last_grant wins
    always_comb begin
        cand  = CDB_rts & ~CDB_xmit;
        found = 1'b0;
        sel   = last_grant;
        idx   = last_grant;
        for (int k = NUM_UNITS; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_UNITS);
            if (cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // While a grant is live, last_grant names the unit holding the bus
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            CDB_xmit   <= '0;
            CDB_data   <= '0;
            CDB_source <= '0;
            CDB_write  <= 1'b0;
            last_grant <= IW'(NUM_UNITS - 1);
        end else begin
            CDB_xmit  <= found ? (NUM_UNITS'(1) << sel) : '0;
            CDB_write <= (|CDB_xmit) & unit_write[last_grant];
            if (found)
                last_grant <= sel;
            if (|CDB_xmit) begin
                CDB_data   <= unit_data[int'(last_grant)*DATA_W +: DATA_W];
                CDB_source <= unit_source[int'(last_grant)*TAG_W +: TAG_W];
            end
        end
    end

`ifdef CDB_ERROR_CHECK_EN
    // Any disagreement between strobe and grant covers both violation kinds
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            error <= 1'b0;
        else if (|(unit_write ^ CDB_xmit))
            error <= 1'b1;
    end
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of grant order, broadcast timing, reset abort and error flag.
module tb_cdb_arbiter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   rts = '0;
    logic [3:0]   wr_force = '0;
    logic [127:0] unit_data = {32'd40, 32'd10, 32'd20, 32'd30};
    logic [23:0]  unit_source = {6'd7, 6'd5, 6'd3, 6'd1};
    logic [3:0]   unit_write, xmit;
    logic [31:0]  data;
    logic [5:0]   source;
    logic         write, error;
    int           n_chk = 0;
    int           n_pass = 0;
    int           tg [4] = '{1, 3, 5, 7};
    int           dv [4] = '{30, 20, 10, 40};
`ifdef CDB_ERROR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clock = ~clock;

    assign unit_write = xmit | wr_force;

    cdb_arbiter dut (
        .clock(clock), .reset(reset), .CDB_rts(rts), .unit_data(unit_data),
        .unit_source(unit_source), .unit_write(unit_write), .CDB_xmit(xmit),
        .CDB_data(data), .CDB_source(source), .CDB_write(write), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    initial begin
        do_reset;
        chk("rst_xmit", xmit, 0);
        chk("rst_write", write, 0);
        chk("rst_data", data, 0);
        chk("rst_src", source, 0);
        chk("rst_err", error, 0);

        rts = 4'b0100;
        step;
        chk("single_xmit", xmit, 4'b0100);
        rts = 4'b0000;
        step;
        chk("single_xmit_off", xmit, 0);
        chk("single_data", data, 10);
        chk("single_src", source, 5);
        chk("single_write", write, 1);
        step;
        chk("single_write_off", write, 0);
        chk("single_hold", data, 10);
        chk("single_err", error, 0);

        do_reset;
        rts = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step;
            if (k < 4) begin
                chk("all_xmit", xmit, 32'd1 << k);
                rts[k] = 1'b0;
            end else chk("all_xmit_off", xmit, 0);
            if (k >= 1 && k <= 4) begin
                chk("all_src", source, tg[k-1]);
                chk("all_data", data, dv[k-1]);
                chk("all_write", write, 1);
            end else if (k == 5) chk("all_write_off", write, 0);
        end

        do_reset;
        rts = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            step;
            chk("fair_xmit", xmit, (k % 2) ? 4'b1000 : 4'b0001);
        end

        do_reset;
        rts = 4'b0001;
        step;
        rts = 4'b0010;
        step;
        chk("mid_xmit", xmit, 4'b0010);
        chk("mid_pre_data", data, 30);
        reset = 1'b1;
        #1;
        chk("mid_rst_xmit", xmit, 0);
        chk("mid_rst_write", write, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_src", source, 0);
        step;
        reset = 1'b0;
        step;
        chk("mid_regrant", xmit, 4'b0010);
        rts = 4'b0000;
        step;
        chk("mid_write", write, 1);
        chk("mid_data", data, 20);
        chk("mid_src", source, 3);

        do_reset;
        rts = 4'b0011;
        wr_force = 4'b0010;
        step;
        chk("err_set", error, EXP_ERR);
        chk("err_xmit0", xmit, 4'b0001);
        wr_force = 4'b0000;
        rts = 4'b0010;
        step;
        chk("err_xmit1", xmit, 4'b0010);
        chk("err_src0", source, 1);
        chk("err_write0", write, 1);
        rts = 4'b0000;
        step;
        chk("err_src1", source, 3);
        chk("err_write1", write, 1);
        step;
        chk("err_sticky", error, EXP_ERR);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
